// File: rtl/gated_bus_pipeline_if.sv
// Purpose: bundles the gated pipeline's producer/consumer handshake, data buses and status.
// Latency: n/a (wiring only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready handshakes.
// Ports (via modports):
//   slave  - the pipeline: takes enable/flush/in_valid/data_in/out_ready,
//            drives in_ready/out_valid/data_out/occupancy.
//   master - the environment driving the pipeline (mirror of slave).
interface gated_bus_pipeline_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             enable;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    occupancy;

  modport slave (
    input  enable, flush, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, occupancy
  );

  modport master (
    output enable, flush, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, occupancy
  );
endinterface

// File: rtl/gated_bus_pipeline.sv
// Purpose: elastic DEPTH-stage register pipeline; captured word = data_in & {WIDTH{enable}}.
// Latency: word accepted at edge N is on data_out after edge N+DEPTH-1 (1 word/cycle).
// Backpressure: stalled output holds; empty stages still fill; in_ready drops when all full.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears all valid bits, data and occupancy
//   bus   - gated_bus_pipeline_if.slave (enable, flush, in/out handshakes, data, occupancy)
module gated_bus_pipeline #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gated_bus_pipeline_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            load;
  logic                        carry;
  logic                        accept;
  logic                        out_fire;
  logic [CW-1:0]               occ;

  // load[k]: stage k takes a new word (or a bubble) this cycle. An empty stage always
  // loads; a full stage loads only when its own word moves on, which chains back from
  // the consumer. This is what collapses bubbles under a stalled output.
  always_comb begin
    carry = bus.out_ready;
    load  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      carry   = carry | ~v[k];
      load[k] = carry;
    end
  end

  // No skid buffer: in_ready is combinational from out_ready through the load chain.
  assign bus.in_ready = ~bus.flush & load[0];
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_fire     = v[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v   <= '0;
      d   <= '0;
      occ <= '0;
    end else if (bus.flush) begin
      // Flush drops every word; data registers are left as they are.
      v   <= '0;
      occ <= '0;
    end else begin
      if (load[0]) begin
        v[0] <= accept;
        // enable only matters in the accept cycle; the stored word is frozen after.
        if (accept) d[0] <= bus.data_in & {WIDTH{bus.enable}};
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) begin
          v[k] <= v[k-1];
          // Keep the last real word when a bubble moves in, so data_out never shows junk.
          if (v[k-1]) d[k] <= d[k-1];
        end
      end
      case ({accept, out_fire})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign bus.out_valid = v[DEPTH-1];
  assign bus.data_out  = d[DEPTH-1];
  assign bus.occupancy = occ;

endmodule
